// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core types, including the fetch-stage state, fault causes and next-PC selects.
package riscv_pkg;
  typedef enum logic [1:0] {
    PC_SRC_PC4        = 2'd0,
    PC_SRC_BRANCH_JAL = 2'd1,
    PC_SRC_JALR       = 2'd2
  } pc_src_e;
  typedef enum logic [2:0] {BOOT, REQ, WAIT, VALID, FAULT} fetch_state_e;
  typedef enum logic [1:0] {
    FAULT_NONE       = 2'd0,
    FAULT_ACCESS     = 2'd1,
    FAULT_TIMEOUT    = 2'd2,
    FAULT_MISALIGNED = 2'd3
  } fetch_fault_e;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
endpackage

// File: rtl/fetch_next_pc.sv
// fetch_next_pc: selects the PC that follows a committed instruction and flags targets that are not word aligned.
module fetch_next_pc
  import riscv_pkg::*;
(
  input  pc_src_e     pc_src,
  input  logic [31:0] pc,
  input  logic [31:0] branch_target,
  input  logic [31:0] jalr_target,
  output logic [31:0] next_pc,
  output logic        misaligned
);
  // Any select other than a branch or JALR, including unused encodings, falls through to sequential fetch.
  always_comb begin
    next_pc    = pc_src == PC_SRC_JALR ? {jalr_target[31:1], 1'b0} :
                 pc_src == PC_SRC_BRANCH_JAL ? branch_target : pc + 32'd4;
    misaligned = next_pc[1];
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, fetches one instruction at a time and holds it until commit;
// access errors, timeouts and misaligned targets park it in a sticky fault state.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  pc_src_e      pc_src,
  input  logic [31:0]  branch_target,
  input  logic [31:0]  jalr_target,
  input  logic         instr_ack,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_rvalid,
  input  logic [31:0]  imem_rdata,
  input  logic         imem_err,
  output logic [31:0]  instr,
  output logic         instr_valid,
  output logic [31:0]  pc,
  output logic [31:0]  pc_plus4,
  output logic         fetch_fault,
  output fetch_fault_e fault_cause,
  output logic [31:0]  fault_pc
);
  localparam int unsigned   CW       = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  fetch_state_e state_q;
  fetch_fault_e cause_q;
  logic [CW-1:0] cnt_q;
  logic [31:0] pc_q, pc_d, instr_q, fault_pc_q;
  logic req_q, valid_q, fault_q, misaligned, timeout;
  fetch_next_pc u_next_pc (
    .pc_src       (pc_src),
    .pc           (pc_q),
    .branch_target(branch_target),
    .jalr_target  (jalr_target),
    .next_pc      (pc_d),
    .misaligned   (misaligned)
  );
  assign timeout     = TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST;
  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign fetch_fault = fault_q;
  assign fault_cause = cause_q;
  assign fault_pc    = fault_pc_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      instr_q    <= INSTR_NOP;
      valid_q    <= 1'b0;
      req_q      <= 1'b0;
      fault_q    <= 1'b0;
      cause_q    <= FAULT_NONE;
      fault_pc_q <= '0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q <= REQ;
          req_q   <= 1'b1;
        end
        REQ: begin
          state_q <= WAIT;
          req_q   <= 1'b0;
          cnt_q   <= '0;
        end
        WAIT: begin
          cnt_q <= cnt_q + CW'(1);
          // A response arriving on the timeout cycle still counts as a response.
          if (imem_rvalid && !imem_err) begin
            instr_q <= imem_rdata;
            valid_q <= 1'b1;
            state_q <= VALID;
          end else if (imem_rvalid || timeout) begin
            fault_q    <= 1'b1;
            cause_q    <= imem_rvalid ? FAULT_ACCESS : FAULT_TIMEOUT;
            fault_pc_q <= pc_q;
            state_q    <= FAULT;
          end
        end
        VALID: begin
          if (instr_ack) begin
            valid_q <= 1'b0;
            if (misaligned) begin
              fault_q    <= 1'b1;
              cause_q    <= FAULT_MISALIGNED;
              fault_pc_q <= pc_d;
              state_q    <= FAULT;
            end else begin
              pc_q    <= pc_d;
              req_q   <= 1'b1;
              state_q <= REQ;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized fetch traffic against a PC-tracking reference model;
// a monitor pops expected requests, fetched words and faults from a scoreboard queue.
module tb_instr_fetch_unit;
  import riscv_pkg::*;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int K_REQ = 0, K_VALID = 1, K_FAULT = 2;
  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
  } ev_t;
  logic clk = 1'b0, rst_n;
  pc_src_e pc_src;
  logic [31:0] branch_target, jalr_target, imem_addr, imem_rdata, instr, pc, pc_plus4, fault_pc;
  logic instr_ack, imem_req, imem_rvalid, imem_err, instr_valid, fetch_fault;
  fetch_fault_e fault_cause;
  int n_checks = 0, errs = 0, cyc = 0, req_cyc = 0;
  ev_t q[$];
  logic [31:0] m_pc;
  logic [31:0] cur_i, cur_pc;
  bit pv = 0, pf = 0;

  instr_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .branch_target(branch_target),
    .jalr_target(jalr_target), .instr_ack(instr_ack), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .imem_err(imem_err), .instr(instr), .instr_valid(instr_valid), .pc(pc),
    .pc_plus4(pc_plus4), .fetch_fault(fetch_fault), .fault_cause(fault_cause),
    .fault_pc(fault_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pop(input int k, output ev_t e, output bit ok);
    n_checks++;
    ok = 1'b0;
    if (q.size() == 0) begin
      errs++;
      $display("FAIL unexpected_event: got kind %0d expected none", k);
    end else begin
      e = q.pop_front();
      ok = e.kind == k;
      if (!ok) begin
        errs++;
        $display("FAIL event_order: got kind %0d expected kind %0d", k, e.kind);
      end
    end
  endtask

  function automatic logic [31:0] model_next(input int s, input logic [31:0] p, input logic [31:0] bt,
                                             input logic [31:0] jt);
    if (s == 2) return jt & 32'hFFFF_FFFE;
    if (s == 1) return bt;
    return p + 32'd4;
  endfunction

  always @(negedge clk) begin
    ev_t e;
    bit ok;
    cyc++;
    if (!rst_n) begin
      pv = 0;
      pf = 0;
    end else begin
      if (imem_req) begin
        pop(K_REQ, e, ok);
        if (ok) chk("req_addr", imem_addr, e.a);
        req_cyc = cyc;
      end
      if (instr_valid && !pv) begin
        pop(K_VALID, e, ok);
        if (ok) begin
          chk("instr", instr, e.a);
          chk("pc", pc, e.b);
          chk("pc_plus4", pc_plus4, e.b + 32'd4);
          chk("valid_latency", 32'(cyc - req_cyc), 32'(e.lat));
        end
        cur_i  = ok ? e.a : instr;
        cur_pc = ok ? e.b : pc;
      end else if (instr_valid) begin
        chk("hold_instr", instr, cur_i);
        chk("hold_pc", pc, cur_pc);
      end
      if (fetch_fault && !pf) begin
        pop(K_FAULT, e, ok);
        if (ok) begin
          chk("fault_cause", 32'(fault_cause), e.a);
          chk("fault_pc", fault_pc, e.b);
          if (e.lat != 0) chk("fault_latency", 32'(cyc - req_cyc), 32'(e.lat));
        end
      end
      if (fetch_fault) chk("fault_quiet", {30'd0, imem_req, instr_valid}, 32'd0);
      pv = instr_valid;
      pf = fetch_fault;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_check();
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, INSTR_NOP);
    chk("rst_pc", pc, RST_PC);
    chk("rst_pc_plus4", pc_plus4, RST_PC + 32'd4);
    chk("rst_fetch_fault", 32'(fetch_fault), 32'd0);
    chk("rst_fault_cause", 32'(fault_cause), 32'(FAULT_NONE));
    chk("rst_fault_pc", fault_pc, 32'd0);
  endtask

  // Asynchronous reset is asserted mid-cycle and checked before any clock edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    reset_check();
    q.delete();
    instr_ack = 1'b0;
    imem_rvalid = 1'b0;
    imem_err = 1'b0;
    m_pc = RST_PC;
    step();
    q.push_back('{K_REQ, RST_PC, 32'd0, 0});
    rst_n = 1'b1;
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    while (!imem_req && n < 20) begin
      step();
      n++;
    end
    ok = imem_req;
    n_checks++;
    if (!ok) begin
      errs++;
      $display("FAIL req_wait: got no imem_req after %0d cycles expected one", n);
    end
  endtask

  task automatic do_instr(input int lat, input bit err, input bit tmo, input int hold, input int s,
                          input logic [31:0] bt, input logic [31:0] jt, input logic [31:0] rd,
                          output bit alive);
    bit ok;
    logic [31:0] nx;
    alive = 1'b0;
    wait_req(ok);
    if (!ok) return;
    if (tmo) begin
      q.push_back('{K_FAULT, 32'(FAULT_TIMEOUT), m_pc, 9});
      repeat (14) begin
        instr_ack = 1'($urandom);
        step();
      end
      instr_ack = 1'b0;
      return;
    end
    repeat (1 + lat) begin
      instr_ack = 1'($urandom);
      pc_src = pc_src_e'($urandom_range(0, 3));
      step();
    end
    instr_ack = 1'b0;
    imem_rvalid = 1'b1;
    imem_err = err;
    imem_rdata = rd;
    if (err) q.push_back('{K_FAULT, 32'(FAULT_ACCESS), m_pc, 2 + lat});
    else q.push_back('{K_VALID, rd, m_pc, 2 + lat});
    step();
    imem_rvalid = 1'b0;
    imem_err = 1'b0;
    imem_rdata = $urandom;
    if (err) begin
      repeat (3) step();
      return;
    end
    repeat (hold) begin
      pc_src = pc_src_e'($urandom_range(0, 3));
      branch_target = $urandom;
      jalr_target = $urandom;
      step();
    end
    pc_src = pc_src_e'(s[1:0]);
    branch_target = bt;
    jalr_target = jt;
    instr_ack = 1'b1;
    nx = model_next(s, m_pc, bt, jt);
    if (nx[1]) q.push_back('{K_FAULT, 32'(FAULT_MISALIGNED), nx, 0});
    else begin
      q.push_back('{K_REQ, nx, 32'd0, 0});
      m_pc = nx;
    end
    step();
    instr_ack = 1'b0;
    alive = !nx[1];
    if (!alive) repeat (4) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit alive, ok;
    rst_n = 1'b0;
    instr_ack = 1'b0;
    imem_rvalid = 1'b0;
    imem_err = 1'b0;
    imem_rdata = '0;
    pc_src = PC_SRC_PC4;
    branch_target = '0;
    jalr_target = '0;
    #7;
    reset_check();
    step();
    m_pc = RST_PC;
    q.push_back('{K_REQ, RST_PC, 32'd0, 0});
    rst_n = 1'b1;
    do_instr(0, 0, 0, 0, 0, 32'd0, 32'd0, 32'h0050_0093, alive);
    do_instr(1, 0, 0, 10, 1, 32'h200, 32'd0, $urandom, alive);
    do_instr(2, 0, 0, 1, 2, 32'd0, 32'h301, $urandom, alive);
    do_instr(0, 0, 0, 0, 2, 32'd0, 32'h302, $urandom, alive);
    do_reset();
    do_instr(0, 0, 0, 0, 0, 32'd0, 32'd0, $urandom, alive);
    do_instr(3, 1, 0, 0, 0, 32'd0, 32'd0, $urandom, alive);
    do_reset();
    do_instr(0, 0, 1, 0, 0, 32'd0, 32'd0, $urandom, alive);
    do_reset();
    do_instr(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'd0, $urandom, alive);
    do_instr(0, 0, 0, 0, 0, 32'd0, 32'd0, $urandom, alive);
    do_instr(1, 0, 0, 2, 3, 32'h40, 32'h80, $urandom, alive);
    wait_req(ok);
    step();
    do_reset();
    for (int i = 0; i < 80; i++) begin
      logic [31:0] bt, jt;
      bt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) == 0) bt[1] = 1'b1;
      jt = $urandom;
      if ($urandom_range(0, 3) != 0) jt[1] = 1'b0;
      do_instr($urandom_range(0, 5), $urandom_range(0, 15) == 0, 0, $urandom_range(0, 3),
               $urandom_range(0, 3), bt, jt, $urandom, alive);
      if (!alive) do_reset();
    end
    repeat (5) step();
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, n_checks);
    $finish;
  end
endmodule
